// File: rtl/pipe_stall_ctl_pkg.sv
// Shared opcode constants, FSM state encoding and stall-cause encoding for
// the pipeline stall controller.
package pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] FN_MUL   = 6'd25;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CTRL     = 2'd1,
      ST_MUL_WAIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_LOAD_USE = 2'd1,
      CAUSE_CTRL     = 2'd2,
      CAUSE_MUL      = 2'd3
   } stall_cause_e;

   function automatic logic is_branch(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   function automatic logic is_jump(input logic [5:0] op);
      return op == OP_J;
   endfunction

   // A mul is only visible in the IF stage as an R-type; it is handled
   // later from ID/EX, so this is informational and never stalls fetch.
   function automatic logic is_mul_rtype(input logic [31:0] instr);
      return (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_MUL);
   endfunction

endpackage

// File: rtl/pipe_stall_ctl_if.sv
// Pipeline-facing signal bundle of the stall controller. The pipeline side
// is the master (drives hazard inputs), the controller is the slave.
interface pipe_stall_ctl_if
   import pipe_pkg::*;
#(
   parameter int REG_AW = 5
);
   logic [31:0]       if_instr;
   logic [REG_AW-1:0] ifid_rs;
   logic [REG_AW-1:0] ifid_rt;
   logic              idex_memread;
   logic [REG_AW-1:0] idex_rt;
   logic              idex_is_mul;
   logic              ex_mul_done;
   logic              pc_en;
   logic              ifid_en;
   logic              idex_en;
   logic              ifid_flush;
   logic              idex_flush;
   logic              exmem_flush;
   stall_cause_e      stall_cause;
   logic              busy;
   logic              err;

   modport master (
      output if_instr, ifid_rs, ifid_rt, idex_memread, idex_rt, idex_is_mul, ex_mul_done,
      input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, stall_cause, busy, err
   );

   modport slave (
      input  if_instr, ifid_rs, ifid_rt, idex_memread, idex_rt, idex_is_mul, ex_mul_done,
      output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, stall_cause, busy, err
   );
endinterface

// File: rtl/pipe_stall_ctl_stall_cnt.sv
// Loadable down-counter for the control-stall bubble count. Holds its value
// whenever dec is low so a higher-priority hazard can freeze it.
module stall_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero,
   output logic         last
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count: load wins, otherwise decrement toward zero when enabled
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // count register, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);
   assign last = (cnt_q == W'(1));
endmodule

// File: rtl/pipe_stall_ctl.sv
// Pipeline stall controller: load-use bubbles, branch/jump fetch bubbles and
// multiplier waits with a timeout. Outputs are combinational from state,
// counters and the hazard inputs.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_IDLE     | normal flow; watch for hazards and control instructions
//   ST_CTRL     | fetch bubbles after beq/bne/j; stall_cnt holds remaining
//   ST_MUL_WAIT | multiplier busy; ret_q holds the state to resume
module pipe_stall_ctl
   import pipe_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int BR_STALL = 3,
   parameter int J_STALL  = 3,
   parameter int MUL_TMO  = 64
) (
   input  logic            clk,
   input  logic            rst,
   pipe_stall_ctl_if.slave bus
);
   localparam int CMAX  = (BR_STALL > J_STALL) ? BR_STALL : J_STALL;
   localparam int CW    = $clog2(CMAX + 1);
   localparam int TMO_W = $clog2(MUL_TMO + 1);

   state_e             state_q, state_d;
   state_e             ret_q, ret_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               err_q, err_d;

   logic [REG_AW-1:0]  rs, rt, ld_rt;
   logic [5:0]         op;
   logic               mul_hz, lu_hz, in_mw, mw_hold;
   state_e             eval_st;
   logic [CW-1:0]      ctrl_len;
   logic               cnt_load, cnt_dec, cnt_zero, cnt_last;
   logic [CW-1:0]      cnt_val;
   stall_cause_e       cause;
   logic               pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush;

   assign rs     = bus.ifid_rs;
   assign rt     = bus.ifid_rt;
   assign ld_rt  = bus.idex_rt;
   assign op     = bus.if_instr[31:26];
   assign mul_hz = bus.idex_is_mul && !bus.ex_mul_done;
   assign lu_hz  = bus.idex_memread && (ld_rt != '0) && ((ld_rt == rs) || (ld_rt == rt));
   assign in_mw  = (state_q == ST_MUL_WAIT);
   // a wait keeps holding only while the multiplier is busy and time remains
   assign mw_hold = in_mw && mul_hz && (tmo_q != '0);
   // a released wait behaves, for that cycle, like the state it interrupted
   assign eval_st = in_mw ? ret_q : state_q;

   assign ctrl_len = is_branch(op) ? CW'(BR_STALL) :
                     is_jump(op)   ? CW'(J_STALL)  : '0;

   stall_cnt #(.W(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero),
      .last     (cnt_last)
   );

   // hazard priority resolution, next-state and output decode
   always_comb begin
      state_d     = in_mw ? ret_q : state_q;
      ret_d       = ret_q;
      tmo_d       = tmo_q;
      err_d       = err_q;
      cnt_load    = 1'b0;
      cnt_val     = '0;
      cnt_dec     = 1'b0;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      cause       = CAUSE_NONE;

      if (mw_hold || (!in_mw && mul_hz)) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_flush = 1'b1;
         cause       = CAUSE_MUL;
         state_d     = ST_MUL_WAIT;
         if (in_mw) begin
            tmo_d = tmo_q - TMO_W'(1);
         end else begin
            ret_d = state_q;
            tmo_d = TMO_W'(MUL_TMO - 1);
         end
         if (tmo_d == '0) err_d = 1'b1;
      end else if (lu_hz) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         cause      = CAUSE_LOAD_USE;
      end else if (eval_st == ST_CTRL) begin
         ifid_flush = 1'b1;
         cause      = CAUSE_CTRL;
         cnt_dec    = 1'b1;
         pc_en      = cnt_last || cnt_zero;
         if (cnt_last || cnt_zero) state_d = ST_IDLE;
      end else if (ctrl_len != '0) begin
         pc_en    = 1'b0;
         cause    = CAUSE_CTRL;
         cnt_load = 1'b1;
         cnt_val  = ctrl_len;
         state_d  = ST_CTRL;
      end

      // reset parks the pipeline: nothing advances, every stage loads a bubble
      if (!rst) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         cause       = CAUSE_NONE;
      end
   end

   // state, return state, mul timeout and sticky error registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ret_q   <= ST_IDLE;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.ifid_en     = ifid_en;
   assign bus.idex_en     = idex_en;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_flush  = idex_flush;
   assign bus.exmem_flush = exmem_flush;
   assign bus.stall_cause = cause;
   assign bus.busy        = rst && (state_q != ST_IDLE);
   assign bus.err         = rst && err_q;
endmodule
